// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-read-port register file.
// The REGFILE_BYPASS_EN build option is handled in regfile_mp.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // Upper bounds for the generic port slicer; NREAD*ADDR_W must fit FLAT_MAX.
  localparam int SLICE_MAX = 64;
  localparam int FLAT_MAX  = 256;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } rf_state_e;

  function automatic logic [SLICE_MAX-1:0] port_slice(input logic [FLAT_MAX-1:0] flat,
                                                      input int w, input int k);
    logic [FLAT_MAX-1:0] sh;
    sh = flat >> (k * w);
    return sh[SLICE_MAX-1:0];
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback-facing bus of the register file.
// master = pipeline side, slave = regfile_mp.
interface regfile_mp_if import regfile_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NREAD  = 2
) ();

  logic                      clr_req;
  logic [NREAD-1:0]          rd_en;
  logic [NREAD*ADDR_W-1:0]   rd_addr;
  logic [NREAD*DATA_W-1:0]   rd_data;
  logic                      wr_en;
  logic [ADDR_W-1:0]         wr_addr;
  logic [DATA_W-1:0]         wr_data;
  logic                      busy;
  logic                      wr_drop;

  modport master (
    output clr_req, rd_en, rd_addr, wr_en, wr_addr, wr_data,
    input  rd_data, busy, wr_drop
  );

  modport slave (
    input  clr_req, rd_en, rd_addr, wr_en, wr_addr, wr_data,
    output rd_data, busy, wr_drop
  );

endinterface

// File: rtl/regfile_clear_fsm.sv
// Clear sequencer: walks every entry writing zero after reset or on clr_req,
// and flags writes that arrive while the sequence is running.
//
// state | meaning
// CLEAR | writing 0 to mem[ptr], ptr++; exits after ptr = DEPTH-1
// IDLE  | normal operation; clr_req restarts the sweep at ptr = 0
module regfile_clear_fsm import regfile_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  input  logic              wr_en,
  output logic              busy,
  output logic              wr_drop,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              busy_q, busy_d;
  logic              wr_drop_q, wr_drop_d;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    busy_d    = busy_q;
    wr_drop_d = 1'b0;
    if (state_q == CLEAR) begin
      wr_drop_d = wr_en;
      ptr_d     = ptr_q + ADDR_W'(1);
      if (ptr_q == '1) begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    end else if (clr_req) begin
      state_d = CLEAR;
      ptr_d   = '0;
      busy_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CLEAR;
      ptr_q     <= '0;
      busy_q    <= 1'b1;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      busy_q    <= busy_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  assign busy     = busy_q;
  assign wr_drop  = wr_drop_q;
  assign clr_we   = (state_q == CLEAR);
  assign clr_addr = ptr_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised NREAD-port register file with hardwired-zero r0 and clear engine.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_mp import regfile_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NREAD  = 2
) (
  input  logic         clk,
  input  logic         rst,
  regfile_mp_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                busy;
  logic                clr_we;
  logic [ADDR_W-1:0]   clr_addr;
  logic                user_we;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [FLAT_MAX-1:0] rd_addr_pad;

  regfile_clear_fsm #(.ADDR_W(ADDR_W)) u_clear_fsm (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (bus.clr_req),
    .wr_en    (bus.wr_en),
    .busy     (busy),
    .wr_drop  (bus.wr_drop),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign bus.busy = busy;
  assign user_we  = bus.wr_en && (bus.wr_addr != '0) && !busy;

  // The clear sweep owns the write port whenever it runs.
  always_comb begin
    mem_we    = user_we;
    mem_waddr = bus.wr_addr;
    mem_wdata = bus.wr_data;
    if (clr_we) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr;
      mem_wdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign rd_addr_pad = FLAT_MAX'(bus.rd_addr);

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd_q, rd_d;
    logic              hit;

    assign ra = ADDR_W'(port_slice(rd_addr_pad, ADDR_W, k));

`ifdef REGFILE_BYPASS_EN
    assign hit = user_we && (bus.wr_addr == ra);
`else
    assign hit = 1'b0;
`endif

    always_comb begin
      rd_d = rd_q;
      if (busy) begin
        rd_d = '0;
      end else if (bus.rd_en[k]) begin
        if (ra == '0)  rd_d = '0;
        else if (hit)  rd_d = bus.wr_data;
        else           rd_d = mem_q[ra];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) rd_q <= '0;
      else     rd_q <= rd_d;
    end

    assign bus.rd_data[k*DATA_W +: DATA_W] = rd_q;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: read expectations are queued at issue time
// and popped by a monitor one cycle later; control outputs are checked inline.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

`ifdef REGFILE_BYPASS_EN
  localparam logic [31:0] BYP_EXP = 32'hA5A5_A5A5;
`else
  localparam logic [31:0] BYP_EXP = 32'h0000_0001;
`endif

  typedef struct {
    logic [31:0] exp;
    string       nm;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cyc_n;
  exp_t sbq[$];

  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR)) bus ();

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc_n++;
  endtask

  task automatic monitor();
    logic [1:0] en_s;
    exp_t       e;
    forever begin
      @(posedge clk);
      en_s = bus.rd_en;
      @(negedge clk);
      for (int k = 0; k < NR; k++) begin
        if (en_s[k]) begin
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: port %0d produced 0x%08h with nothing expected",
                     k, bus.rd_data[k*DW +: DW]);
          end else begin
            e = sbq.pop_front();
            chk(e.nm, bus.rd_data[k*DW +: DW], e.exp);
          end
        end
      end
    end
  endtask

  task automatic cyc(input logic [1:0] en,
                     input logic [4:0] a0, input logic [31:0] e0,
                     input logic [4:0] a1, input logic [31:0] e1,
                     input logic we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic clr, input string nm);
    exp_t t;
    bus.rd_en   = en;
    bus.rd_addr = {a1, a0};
    bus.wr_en   = we;
    bus.wr_addr = wa;
    bus.wr_data = wd;
    bus.clr_req = clr;
    if (en[0]) begin t.exp = e0; t.nm = {nm, "_p0"}; sbq.push_back(t); end
    if (en[1]) begin t.exp = e1; t.nm = {nm, "_p1"}; sbq.push_back(t); end
    step();
    bus.rd_en   = '0;
    bus.rd_addr = '0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.clr_req = 1'b0;
  endtask

  task automatic rd2(input logic [4:0] a0, input logic [31:0] e0,
                     input logic [4:0] a1, input logic [31:0] e1, input string nm);
    cyc(2'b11, a0, e0, a1, e1, 1'b0, 5'd0, 32'd0, 1'b0, nm);
  endtask

  task automatic wr(input logic [4:0] wa, input logic [31:0] wd);
    cyc(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, wa, wd, 1'b0, "wr");
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (bus.busy && guard < 200) begin
      step();
      guard++;
    end
  endtask

  initial begin
    int s;
    checks = 0;
    errors = 0;
    cyc_n  = 0;
    rst    = 1'b1;
    bus.clr_req = 1'b0;
    bus.rd_en   = '0;
    bus.rd_addr = '0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    fork
      monitor();
    join_none

    #12;
    chk("rst_busy", 32'(bus.busy), 32'd1);
    chk("rst_wr_drop", 32'(bus.wr_drop), 32'd0);
    chk("rst_rd0", bus.rd_data[31:0], 32'd0);
    chk("rst_rd1", bus.rd_data[63:32], 32'd0);

    @(negedge clk);
    rst = 1'b0;
    s = cyc_n;
    wait_idle();
    chk("reset_busy_len", 32'(cyc_n - s), 32'd32);

    for (int a = 1; a < 32; a++)
      rd2(5'(a), 32'd0, 5'(32 - a), 32'd0, "post_reset_zero");

    wr(5'd5, 32'hDEAD_BEEF);
    rd2(5'd5, 32'hDEAD_BEEF, 5'd5, 32'hDEAD_BEEF, "r5_both");

    wr(5'd0, 32'h1234_5678);
    chk("r0_no_drop", 32'(bus.wr_drop), 32'd0);
    rd2(5'd0, 32'd0, 5'd0, 32'd0, "r0_zero");

    wr(5'd7, 32'h0000_0001);
    cyc(2'b01, 5'd7, BYP_EXP, 5'd0, 32'd0, 1'b1, 5'd7, 32'hA5A5_A5A5, 1'b0, "collision");
    rd2(5'd7, 32'hA5A5_A5A5, 5'd7, 32'hA5A5_A5A5, "r7_after");

    rd2(5'd5, 32'hDEAD_BEEF, 5'd0, 32'd0, "hold_setup");
    cyc(2'b10, 5'd0, 32'd0, 5'd7, 32'hA5A5_A5A5, 1'b0, 5'd0, 32'd0, 1'b0, "p1_only");
    chk("rd0_hold", bus.rd_data[31:0], 32'hDEAD_BEEF);

    wr(5'd3, 32'h0000_0055);
    cyc(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h0000_0099, 1'b1, "clr_with_wr");
    s = cyc_n;
    chk("clr_busy", 32'(bus.busy), 32'd1);
    cyc(2'b01, 5'd5, 32'd0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h0000_0044, 1'b0, "busy_read");
    chk("wr_drop_pulse", 32'(bus.wr_drop), 32'd1);
    cyc(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, "clr_ignored");
    chk("wr_drop_end", 32'(bus.wr_drop), 32'd0);
    wait_idle();
    chk("clr_busy_len", 32'(cyc_n - s), 32'd32);
    rd2(5'd3, 32'd0, 5'd4, 32'd0, "r3_r4_cleared");
    rd2(5'd9, 32'd0, 5'd5, 32'd0, "r9_r5_cleared");

    wr(5'd5, 32'hDEAD_BEEF);
    rd2(5'd5, 32'hDEAD_BEEF, 5'd5, 32'hDEAD_BEEF, "r5_again");
    #2 rst = 1'b1;
    #1;
    chk("async_rst_rd0", bus.rd_data[31:0], 32'd0);
    chk("async_rst_rd1", bus.rd_data[63:32], 32'd0);
    chk("async_rst_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    wait_idle();

    cyc(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, "clr2");
    repeat (9) step();
    wr(5'd6, 32'h0000_0066);
    chk("drop_before_rst", 32'(bus.wr_drop), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midclr_rst_drop", 32'(bus.wr_drop), 32'd0);
    chk("midclr_rst_busy", 32'(bus.busy), 32'd1);
    chk("midclr_rst_rd0", bus.rd_data[31:0], 32'd0);
    @(negedge clk);
    rst = 1'b0;
    s = cyc_n;
    wait_idle();
    chk("midclr_busy_len", 32'(cyc_n - s), 32'd32);

    wr(5'd2, 32'h0000_0002);
    rd2(5'd2, 32'h0000_0002, 5'd6, 32'd0, "final");
    step();
    step();
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file for the MIPS datapath, replacing the fixed 32×32, 2-read, negedge-write register bank. It provides NREAD registered read ports, one posedge write port, a hardwired-zero entry 0 and a sequenced clear engine that wipes storage after reset or on request. Optional same-cycle write-to-read forwarding is available. It sits between decode (read addresses) and writeback (write port).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NREAD, 2, number of read ports (1..4)
- clk  input  1  clock; all state changes on posedge
- rst  input  1  asynchronous, active-high reset
- clr_req  input  1  request a full storage clear (1-cycle pulse sufficient)
- rd_en  input  NREAD  per-port read enable
- rd_addr  input  NREAD*ADDR_W  read addresses; port k in bits [k*ADDR_W +: ADDR_W]
- rd_data  output  NREAD*DATA_W  registered read data; port k in bits [k*DATA_W +: DATA_W]
- wr_en  input  1  write enable
- wr_addr  input  ADDR_W  write address
- wr_data  input  DATA_W  write data
- busy  output  1  clear sequence in progress
- wr_drop  output  1  one-cycle pulse: a write was discarded because busy

## Operation
- FSM states: CLEAR, IDLE.
- rst asserted: state=CLEAR, clear pointer=0, busy=1, rd_data=0, wr_drop=0, immediately and asynchronously.
- CLEAR: each posedge writes 0 to mem[ptr] and increments ptr. After the posedge that writes DEPTH-1, state=IDLE and busy=0. busy is therefore high for exactly DEPTH posedges after rst release.
- IDLE with clr_req=1 at a posedge: state=CLEAR, ptr=0, busy=1 from the next cycle. clr_req during CLEAR is ignored and does not restart the sequence.
- Write, IDLE: wr_en=1 and wr_addr≠0 stores wr_data at the posedge. wr_addr=0 is silently discarded and does not pulse wr_drop.
- Write, CLEAR: discarded. wr_drop=1 for the following cycle.
- Same-cycle clr_req and wr_en in IDLE: the write commits, then the clear starts. The written value is later cleared.
- Read: at a posedge with rd_en[k]=1, rd_data[k] loads mem[rd_addr[k]]. With rd_en[k]=0, rd_data[k] holds its value. Address 0 always reads 0.
- While busy, all rd_data are forced to 0 at every posedge, regardless of rd_en.
- Multiple read ports may address the same entry; each sees the same value.

## Timing
- Read latency 1: address sampled at posedge N, data valid after posedge N until the next load.
- Write visible to a read sampled at posedge N+1 or later.
- Read and write to the same nonzero address at the same posedge: see Configuration.
- Reset in mid-clear restarts at ptr=0. Reset in mid-write: the write is lost and the entry is cleared by the sequence.
- wr_drop is a registered output, 0 at reset.

## Configuration
- REGFILE_BYPASS_EN defined: a same-posedge collision (wr_en=1, wr_addr=rd_addr[k]≠0, rd_en[k]=1, IDLE) loads rd_data[k] with wr_data. This gives write-through forwarding so the pipeline needs no writeback hazard stall.
- Not defined: a collision loads the old stored value. The new value is visible from the next read.

## Structure
- regfile_pkg holds:
  - state enum (CLEAR, IDLE)
  - default DATA_W and ADDR_W constants
  - a function to slice a flattened port
- One sub-module, regfile_clear_fsm, owns state, ptr, busy and wr_drop. It drives the clear write into the storage mux.
- Storage array, write mux, read registers and bypass compare live in regfile_mp.

## Test plan
- Reset release with DEPTH=32: busy stays high 32 cycles then drops; reads of addresses 1..31 return 0x00000000.
- IDLE: write 0xDEADBEEF to r5, then read port 0 r5 and port 1 r5 the next cycle. Both return 0xDEADBEEF one cycle later.
- Write 0x12345678 to r0, then read r0: returns 0. wr_drop stays 0.
- Same-posedge write 0xA5A5A5A5 to r7 and read r7, with r7 previously 0x1: returns 0xA5A5A5A5 with REGFILE_BYPASS_EN and 0x00000001 without.
- clr_req after r3=0x55 is written: busy high 32 cycles. A write to r4 during the clear sets wr_drop for 1 cycle. Afterwards r3 and r4 read 0.
- rst asserted at ptr=10 mid-clear: rd_data goes 0 asynchronously, and busy lasts a full 32 cycles after release.
